// File: rtl/selevy_gout_tx.sv
// selevy_gout_tx: turns every change of the 4-bit gout into an ASCII hex
// character, queues it, and sends the queue out as UART frames.
//   CLK        in   system clock, all state on posedge
//   reset      in   asynchronous active-high reset
//   gout       in   [3:0] core general output, sampled every CLK
//   tx         out  UART serial line, idles high
//   busy       out  high while a frame is on the line
//   overflow   out  sticky, set when a change is dropped on a full queue
//   fifo_level out  [log2(FIFO_DEPTH):0] number of queued characters
// Build option: define GOUT_TX_PARITY_EN for 8E1 frames (default 8N1).
module selevy_gout_tx #(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         CLK,
   input  logic                         reset,
   input  logic [3:0]                   gout,
   output logic                         tx,
   output logic                         busy,
   output logic                         overflow,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [3:0]  gout_q, gout_d;
   logic [AW:0] wr_q, wr_d, rd_q, rd_d, level_q, level_d;
   logic        ovf_q, ovf_d, tx_q, tx_d, busy_q, busy_d;
   logic [7:0]  mem [FIFO_DEPTH];
   logic [7:0]  chr, rd_data;
   logic        change, empty, full, push, pop, baud_end;
`ifdef GOUT_TX_PARITY_EN
   logic        par_q, par_d;
`endif
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign overflow   = ovf_q;
   assign fifo_level = level_q;
   assign rd_data    = mem[rd_q[AW-1:0]];
   always_comb begin
      gout_d   = gout;
      change   = gout != gout_q;
      chr      = (gout < 4'd10) ? 8'h30 + {4'h0, gout} : 8'h37 + {4'h0, gout};
      empty    = wr_q == rd_q;
      // full when the pointers address the same slot but are a lap apart
      full     = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
      baud_end = baud_q == 16'(CLK_DIV - 1);
      state_d  = state_q;
      baud_d   = baud_end ? 16'd0 : baud_q + 16'd1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      pop      = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = 16'd0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = rd_data;
               state_d = START;
            end
         end
         START: if (baud_end) state_d = DATA;
         DATA: if (baud_end) begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
`ifdef GOUT_TX_PARITY_EN
            if (bit_q == 3'd7) state_d = PARITY;
`else
            if (bit_q == 3'd7) state_d = STOP;
`endif
         end
         PARITY: if (baud_end) state_d = STOP;
         STOP: if (baud_end) begin
            // chain straight into the next frame when more is queued
            if (!empty) begin
               pop     = 1'b1;
               shift_d = rd_data;
               state_d = START;
            end else state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // a pop in the same cycle frees the slot, so a full queue still accepts
      push    = change && (!full || pop);
      ovf_d   = ovf_q | (change & full & !pop);
      wr_d    = wr_q + {{AW{1'b0}}, push};
      rd_d    = rd_q + {{AW{1'b0}}, pop};
      level_d = wr_d - rd_d;
`ifdef GOUT_TX_PARITY_EN
      par_d   = pop ? ^rd_data : par_q;
`endif
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef GOUT_TX_PARITY_EN
         PARITY:  tx_d = par_d;
`endif
         default: tx_d = 1'b1;
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         gout_q  <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         gout_q  <= gout_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end
`ifdef GOUT_TX_PARITY_EN
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) par_q <= 1'b0;
      else par_q <= par_d;
   end
`endif
   always_ff @(posedge CLK) begin
      if (push) mem[wr_q[AW-1:0]] <= chr;
   end
endmodule

// File: tb/tb_selevy_gout_tx.sv
// tb_selevy_gout_tx: directed bench for selevy_gout_tx (CLK_DIV=4, FIFO_DEPTH=4).
module tb_selevy_gout_tx;
`ifdef GOUT_TX_PARITY_EN
   localparam int FL = 44;
`else
   localparam int FL = 40;
`endif
   logic       CLK = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] gout = 4'h0;
   logic       tx, busy, overflow;
   logic [2:0] fifo_level;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int peak = 0;
   selevy_gout_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
      .CLK(CLK), .reset(reset), .gout(gout), .tx(tx), .busy(busy),
      .overflow(overflow), .fifo_level(fifo_level)
   );
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic do_reset();
      @(negedge CLK);
      reset = 1'b1;
      gout  = 4'h0;
      repeat (3) @(negedge CLK);
      reset = 1'b0;
      repeat (2) @(negedge CLK);
   endtask
   task automatic find_start(input int budget, output logic ok, output int s);
      ok = 1'b0;
      s  = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (int'(fifo_level) > peak) peak = int'(fifo_level);
         if (tx === 1'b0) begin
            ok = 1'b1;
            s  = cyc;
            break;
         end
      end
   endtask
   // called on the first sampled cycle of a start bit; returns on the last frame cycle
   task automatic cap(output logic [7:0] d, output logic p, output logic st,
                      output logic sp, output int bc);
      d = 8'h00; p = 1'b0; st = 1'b0; sp = 1'b0; bc = 0;
      for (int c = 0; c < FL; c++) begin
         if (c > 0) @(negedge CLK);
         if (int'(fifo_level) > peak) peak = int'(fifo_level);
         if (busy === 1'b1) bc++;
         if (c == 2) st = ~tx;
         if (c >= 6 && c <= 34 && c % 4 == 2) d[(c - 6) / 4] = tx;
         if (c == 38) p = tx;
         if (c == FL - 2) sp = tx;
      end
   endtask
   initial begin
      logic [7:0] d;
      logic       p, st, sp, ok;
      int         bc, s1, s2, bad;
      // reset state and long idle with gout steady at 0
      repeat (3) @(negedge CLK);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_level", fifo_level, 0);
      reset = 1'b0;
      bad = 0;
      repeat (100) begin
         @(negedge CLK);
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) bad++;
      end
      chk("idle_100", bad, 0);
      // single change 0->5, latency and frame content
      @(posedge CLK) #1 gout = 4'h5;
      @(negedge CLK);
      chk("lat_level0", fifo_level, 0);
      @(negedge CLK);
      chk("lat_level1", fifo_level, 1);
      chk("lat_tx_high", tx, 1);
      @(negedge CLK);
      chk("lat_tx_low", tx, 0);
      chk("lat_busy", busy, 1);
      cap(d, p, st, sp, bc);
      chk("f5_data", d, 8'h35);
      chk("f5_start", st, 1);
      chk("f5_stop", sp, 1);
      chk("f5_busy_len", bc, FL);
`ifdef GOUT_TX_PARITY_EN
      chk("f5_parity", p, 0);
`endif
      @(negedge CLK);
      chk("f5_busy_end", busy, 0);
      chk("f5_tx_end", tx, 1);
      chk("f5_ovf", overflow, 0);
      // 0->A->F on consecutive cycles, back-to-back frames
      do_reset();
      peak = 0;
      @(posedge CLK) #1 gout = 4'hA;
      @(posedge CLK) #1 gout = 4'hF;
      find_start(20, ok, s1);
      chk("af_start1", ok, 1);
      cap(d, p, st, sp, bc);
      chk("af_data1", d, 8'h41);
      find_start(20, ok, s2);
      chk("af_start2", ok, 1);
      chk("af_gap", s2 - s1, FL);
      cap(d, p, st, sp, bc);
      chk("af_data2", d, 8'h46);
      chk("af_stop2", sp, 1);
      chk("af_peak", (peak >= 1 && peak <= 2), 1);
      // six changes in six cycles: one in flight, four queued, one dropped
      do_reset();
      fork
         begin
            for (int v = 1; v <= 6; v++) @(posedge CLK) #1 gout = 4'(v);
            @(posedge CLK);
            @(negedge CLK);
            chk("ov_flag", overflow, 1);
            chk("ov_level", fifo_level, 4);
         end
         begin
            for (int k = 0; k < 5; k++) begin
               find_start(100, ok, s1);
               chk("ov_start", ok, 1);
               cap(d, p, st, sp, bc);
               chk("ov_data", d, 8'h31 + 8'(k));
            end
         end
      join
      find_start(100, ok, s1);
      chk("ov_no_sixth", ok, 0);
      chk("ov_sticky", overflow, 1);
      chk("ov_level_end", fifo_level, 0);
      // reset mid-data of '7'
      do_reset();
      gout = 4'h7;
      find_start(20, ok, s1);
      chk("mr_start", ok, 1);
      repeat (10) @(negedge CLK);
      chk("mr_busy_pre", busy, 1);
      #1 reset = 1'b1;
      gout = 4'h0;
      #1;
      chk("mr_tx", tx, 1);
      chk("mr_busy", busy, 0);
      chk("mr_level", fifo_level, 0);
      chk("mr_ovf", overflow, 0);
      repeat (3) @(negedge CLK);
      reset = 1'b0;
      bad = 0;
      repeat (100) begin
         @(negedge CLK);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("mr_quiet", bad, 0);
      // 0->3, frame length and parity bit
      do_reset();
      gout = 4'h3;
      find_start(20, ok, s1);
      chk("f3_start", ok, 1);
      cap(d, p, st, sp, bc);
      chk("f3_data", d, 8'h33);
      chk("f3_stop", sp, 1);
      chk("f3_len", bc, FL);
`ifdef GOUT_TX_PARITY_EN
      chk("f3_parity", p, 0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
